// File: rtl/hrange_arb_pkg.sv
// Shared types and default sizing for the hrange round-robin arbiter.
// The state enum is used by the arbiter FSM.
package hrange_arb_pkg;

  localparam int DEF_W    = 32;
  localparam int DEF_NREQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/hrange_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit at or above rr_ptr,
// wrapping modulo NREQ. It returns the one-hot grant, the binary index and an any-request flag.
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW:0]       sum;

  // Bit k of rot corresponds to requester (rr_ptr + k) mod NREQ.
  assign dbl = {req, req} >> rr_ptr;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    any = |req;
    sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = (IW+1)'(rr_ptr) + (IW+1)'(k);
    end
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    index = sum[IW-1:0];
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = any && (index == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/hrange_arbiter.sv
// Time-shares one hrange generator among NREQ requesters, round-robin, one job at a time.
// Arguments are latched at grant. Generator outputs are routed to the owner until it completes.
module hrange_arbiter
  import hrange_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic              _clock,
  input  logic              _reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_base,
  input  logic [NREQ*W-1:0] req_limit,
  input  logic [NREQ*W-1:0] req_step,
  input  logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   out_valid,
  output logic [W-1:0]      out_0,
  output logic [W-1:0]      out_1,
  output logic [NREQ-1:0]   done,
  output logic              gen_reset,
  output logic              gen_start,
  output logic              gen_ready,
  output logic [W-1:0]      gen_base,
  output logic [W-1:0]      gen_limit,
  output logic [W-1:0]      gen_step,
  input  logic              gen_valid,
  input  logic              gen_done,
  input  logic [W-1:0]      gen_0,
  input  logic [W-1:0]      gen_1
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic            gen_reset_q;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0]    base_q, base_d;
  logic [W-1:0]    limit_q, limit_d;
  logic [W-1:0]    step_q, step_d;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .index  (pick_idx),
    .any    (pick_any)
  );

  assign gen_reset = gen_reset_q;
  assign gen_start = (state_q == LAUNCH) && !gen_reset_q;
  assign gen_ready = (state_q == RUN) && req_ready[idx_q];
  assign gen_base  = base_q;
  assign gen_limit = limit_q;
  assign gen_step  = step_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign out_0     = gen_0;
  assign out_1     = gen_1;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_out_valid
      assign out_valid[gi] = (state_q == RUN) && grant_q[gi] && gen_valid && req_ready[gi];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    base_d   = base_q;
    limit_d  = limit_q;
    step_d   = step_q;
    case (state_q)
      IDLE: begin
        // The generator must have seen its reset before the first job is handed to it.
        if (!gen_reset_q && pick_any) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          base_d  = req_base[int'(pick_idx) * W +: W];
          limit_d = req_limit[int'(pick_idx) * W +: W];
          step_d  = req_step[int'(pick_idx) * W +: W];
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        if (gen_done && gen_ready) begin
          done_d   = grant_q;
          grant_d  = '0;
          rr_ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q     <= IDLE;
      gen_reset_q <= 1'b1;
      grant_q     <= '0;
      done_q      <= '0;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      base_q      <= '0;
      limit_q     <= '0;
      step_q      <= '0;
    end else begin
      gen_reset_q <= 1'b0;
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      base_q      <= base_d;
      limit_q     <= limit_d;
      step_q      <= step_d;
    end
  end

endmodule

// File: tb/tb_hrange_arbiter.sv
// Self-checking bench for hrange_arbiter with a behavioural hrange generator and a job-level reference model.
// Randomised requests, back-pressure and argument churn are applied on top of directed scenarios.
module tb_hrange_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 32;

  typedef enum int {P_IDLE, P_LAUNCH, P_RUN, P_DONE} phase_t;
  typedef struct packed {
    logic [W-1:0] c0;
    logic [W-1:0] c1;
  } beat_t;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NREQ-1:0]   req       = '0;
  logic [NREQ-1:0]   req_ready = '1;
  logic [NREQ*W-1:0] req_base  = '0;
  logic [NREQ*W-1:0] req_limit = '0;
  logic [NREQ*W-1:0] req_step  = '0;
  logic [NREQ-1:0]   grant, out_valid, done;
  logic [W-1:0]      out_0, out_1, gen_base, gen_limit, gen_step, gen_0, gen_1;
  logic              gen_reset, gen_start, gen_ready, gen_valid, gen_done;

  hrange_arbiter #(.NREQ(NREQ), .W(W)) dut (
    ._clock    (clk),
    ._reset_n  (rst_n),
    .req       (req),
    .req_base  (req_base),
    .req_limit (req_limit),
    .req_step  (req_step),
    .req_ready (req_ready),
    .grant     (grant),
    .out_valid (out_valid),
    .out_0     (out_0),
    .out_1     (out_1),
    .done      (done),
    .gen_reset (gen_reset),
    .gen_start (gen_start),
    .gen_ready (gen_ready),
    .gen_base  (gen_base),
    .gen_limit (gen_limit),
    .gen_step  (gen_step),
    .gen_valid (gen_valid),
    .gen_done  (gen_done),
    .gen_0     (gen_0),
    .gen_1     (gen_1)
  );

  always #5 clk = ~clk;

  // Behavioural hrange: _0 = element index, _1 = base + index*step while below limit.
  logic               g_active = 1'b0;
  logic signed [W-1:0] g_v, g_lim, g_step;
  logic [W-1:0]        g_n;

  always @(posedge clk) begin
    if (gen_reset) g_active <= 1'b0;
    else if (gen_start) begin
      g_active <= 1'b1;
      g_v      <= gen_base;
      g_lim    <= gen_limit;
      g_step   <= gen_step;
      g_n      <= '0;
    end else if (g_active && gen_ready) begin
      if (gen_done) g_active <= 1'b0;
      else begin
        g_v <= g_v + g_step;
        g_n <= g_n + 1;
      end
    end
  end

  assign gen_valid = g_active;
  assign gen_done  = g_active && ((g_v + g_step) >= g_lim);
  assign gen_0     = g_n;
  assign gen_1     = g_v;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Reference model state (job level).
  phase_t          m_phase = P_IDLE;
  int              m_ptr   = 0;
  int              m_owner = 0;
  int              rel_cnt = 0;
  bit              have_exp = 1'b0;
  logic [NREQ-1:0] exp_grant = '0;
  logic [NREQ-1:0] exp_done  = '0;
  logic [NREQ-1:0] exp_ov;
  beat_t           exp_q[$];
  beat_t           e;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_grant", grant, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_gen_reset", gen_reset, 1);
      check_eq("rst_gen_start", gen_start, 0);
      m_phase  = P_IDLE;
      m_ptr    = 0;
      have_exp = 1'b0;
      rel_cnt  = 0;
      exp_q.delete();
    end else begin
      check_eq("gen_reset", gen_reset, (rel_cnt == 0));
      if (have_exp) begin
        check_eq("grant", grant, exp_grant);
        check_eq("done", done, exp_done);
      end
      check_eq("gen_start", gen_start, (m_phase == P_LAUNCH));
      check_eq("gen_ready", gen_ready, (m_phase == P_RUN) ? req_ready[m_owner] : 1'b0);
      exp_ov = '0;
      if (m_phase == P_RUN && gen_valid && req_ready[m_owner]) exp_ov[m_owner] = 1'b1;
      check_eq("out_valid", out_valid, exp_ov);
      if (exp_ov != 0) begin
        if (exp_q.size() == 0) check_eq("extra_beat", 1, exp_q.size());
        else begin
          e = exp_q.pop_front();
          check_eq("out_0", out_0, e.c0);
          check_eq("out_1", out_1, e.c1);
        end
      end
      have_exp = 1'b1;
      exp_done = '0;
      case (m_phase)
        P_IDLE: begin
          exp_grant = '0;
          if (rel_cnt >= 1 && req != 0) begin
            int b, l, s, v, n;
            m_owner = pick(req, m_ptr);
            exp_grant[m_owner] = 1'b1;
            b = int'($signed(req_base[m_owner*W +: W]));
            l = int'($signed(req_limit[m_owner*W +: W]));
            s = int'($signed(req_step[m_owner*W +: W]));
            v = b;
            n = 0;
            exp_q.delete();
            while (v < l) begin
              exp_q.push_back({W'(n), W'(v)});
              v += s;
              n++;
            end
            m_phase = P_LAUNCH;
          end
        end
        P_LAUNCH: m_phase = P_RUN;
        P_RUN: begin
          if (gen_done && gen_ready) begin
            check_eq("stream_left", exp_q.size(), 0);
            exp_grant = '0;
            exp_done[m_owner] = 1'b1;
            m_ptr   = (m_owner + 1) % NREQ;
            m_phase = P_DONE;
          end
        end
        default: begin
          exp_grant = '0;
          m_phase   = P_IDLE;
        end
      endcase
      if (rel_cnt < 2) rel_cnt++;
    end
  end

  // Stimulus helpers.
  int bp_mode   = 0;
  bit chaos     = 1'b0;
  bit late_join = 1'b0;

  task automatic set_args(input int i, input int b, input int l, input int s);
    req_base[i*W +: W]  = W'(b);
    req_limit[i*W +: W] = W'(l);
    req_step[i*W +: W]  = W'(s);
  endtask

  task automatic rand_args(input int i);
    int b;
    b = int'($urandom_range(0, 40)) - 20;
    set_args(i, b, b + 1 + int'($urandom_range(0, 20)), 1 + int'($urandom_range(0, 6)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (done[i]) req[i] = 1'b0;
    case (bp_mode)
      1:       req_ready = ~req_ready;
      2:       req_ready = NREQ'($urandom);
      default: req_ready = '1;
    endcase
    if (chaos)
      for (int i = 0; i < NREQ; i++)
        if (grant[i]) rand_args(i);
    if (late_join)
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && !grant[i] && $urandom_range(0, 15) == 0) begin
          rand_args(i);
          req[i] = 1'b1;
        end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req != 0 || m_phase != P_IDLE) && n < budget) begin
      step();
      n++;
    end
    check_eq("idle_wait", (req != 0 || m_phase != P_IDLE), 0);
  endtask

  task automatic wait_bit(input string tag, input logic [NREQ-1:0] mask, input bit use_done, input int budget);
    int n = 0;
    while (((use_done ? done : grant) & mask) == 0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, ((use_done ? done : grant) & mask) != 0, 1);
  endtask

  initial begin
    // 1: reset release with no request.
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("t1_idle_grant", grant, 0);

    // 2: single job on requester 0.
    set_args(0, 1, 11, 3);
    req = 3'b001;
    step();
    check_eq("t2_grant", grant, 3'b001);
    wait_idle(200);

    // Run one job on requester 2 so the pointer wraps back to 0.
    set_args(2, 0, 4, 1);
    req = 3'b100;
    wait_idle(200);

    // 3: simultaneous requests, requester 0 wins, then requester 1, then 0 again.
    set_args(0, 0, 10, 2);
    set_args(1, 1, 11, 3);
    req = 3'b011;
    step();
    check_eq("t3_first", grant, 3'b001);
    wait_bit("t3_second", 3'b010, 1'b0, 200);
    wait_idle(200);
    set_args(0, 0, 10, 2);
    set_args(1, 1, 11, 3);
    req = 3'b011;
    step();
    check_eq("t3_again", grant, 3'b001);
    wait_idle(300);

    // 4: back-pressure toggling 1,0,1,0.
    set_args(0, 0, 10, 2);
    req = 3'b001;
    bp_mode = 1;
    wait_idle(300);
    bp_mode = 0;

    // 5: requester 1 withdraws two cycles into RUN.
    set_args(1, 0, 20, 2);
    req = 3'b010;
    wait_bit("t5_grant", 3'b010, 1'b0, 50);
    step();
    step();
    step();
    req[1] = 1'b0;
    wait_bit("t5_done", 3'b010, 1'b1, 200);
    wait_idle(50);

    // 6: reset during RUN, then a fresh job.
    set_args(2, 0, 100, 1);
    req = 3'b100;
    for (int i = 0; i < 12; i++) step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_grant", grant, 0);
    check_eq("t6_done", done, 0);
    check_eq("t6_gen_reset", gen_reset, 1);
    req = '0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    set_args(0, 0, 10, 2);
    req = 3'b001;
    wait_idle(300);

    // 7: randomised rounds with back-pressure, argument churn and late requests.
    chaos = 1'b1;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NREQ; i++) rand_args(i);
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      bp_mode = int'($urandom_range(0, 2));
      late_join = 1'b1;
      for (int i = 0; i < 20; i++) step();
      late_join = 1'b0;
      wait_idle(3000);
    end
    chaos = 1'b0;
    bp_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
